// File: rtl/dds_9952_pkg.sv
// Shared definitions for the AD9952 command sequencer: register map,
// per-register byte lengths, FSM state encoding and instruction-byte layout.
package dds_9952_pkg;

  localparam logic [4:0] ADDR_CFR1 = 5'h00;
  localparam logic [4:0] ADDR_CFR2 = 5'h01;
  localparam logic [4:0] ADDR_ASF  = 5'h02;
  localparam logic [4:0] ADDR_ARR  = 5'h03;
  localparam logic [4:0] ADDR_FTW0 = 5'h04;
  localparam logic [4:0] ADDR_POW0 = 5'h05;

  // Bit of the instruction byte that selects a register read.
  localparam int INSTR_RD_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_SPACE,
    ST_SEND,
    ST_WAIT_RX
  } state_t;

  // Number of data bytes behind a register; 0 marks an unmapped address.
  function automatic logic [2:0] reg_len(input logic [4:0] addr);
    case (addr)
      ADDR_CFR1: reg_len = 3'd4;
      ADDR_CFR2: reg_len = 3'd3;
      ADDR_ASF:  reg_len = 3'd2;
      ADDR_ARR:  reg_len = 3'd1;
      ADDR_FTW0: reg_len = 3'd4;
      ADDR_POW0: reg_len = 3'd2;
      default:   reg_len = 3'd0;
    endcase
  endfunction

  // Serial-port instruction byte: R/W flag, two zero bits, register address.
  function automatic logic [7:0] instr_byte(input logic rd, input logic [4:0] addr);
    instr_byte = {3'b000, addr};
    instr_byte[INSTR_RD_BIT] = rd;
  endfunction

endpackage

// File: rtl/dds_9952_cmd_seq_if.sv
// Register-command handshake between a host and the AD9952 command sequencer.
interface dds_9952_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, cmd_read, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_read, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/dds_9952_rx_collect.sv
// Collects the MISO bytes of a register read: drops the instruction echo,
// shifts in len data bytes and flags completion or an RX timeout.
module dds_9952_rx_collect #(
  parameter logic [15:0] RX_TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_start,
  input  logic [2:0]  i_len,
  input  logic [7:0]  rx_data,
  input  logic        rx_wrreq,
  output logic        o_done,
  output logic        o_timeout,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid
);

  logic        r_active;
  logic        r_echo_seen;
  logic [2:0]  r_cnt;
  logic [2:0]  r_len;
  logic [15:0] r_timer;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  logic w_byte;
  logic w_done;
  logic w_tmo;

  // A data byte completing the word takes priority over a coincident timeout.
  assign w_byte = r_active & rx_wrreq & r_echo_seen;
  assign w_done = w_byte & (r_cnt == (r_len - 3'd1));
  assign w_tmo  = r_active & ~w_done & (r_timer == (RX_TIMEOUT - 16'd1));

  // Echo skip, shift-in, byte count and timeout timer for one read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_active    <= 1'b0;
      r_echo_seen <= 1'b0;
      r_cnt       <= 3'd0;
      r_len       <= 3'd0;
      r_timer     <= 16'd0;
      r_rd_data   <= 32'd0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_done;
      if (i_start) begin
        r_active    <= 1'b1;
        r_echo_seen <= 1'b0;
        r_cnt       <= 3'd0;
        r_len       <= i_len;
        r_timer     <= 16'd0;
        r_rd_data   <= 32'd0;
      end else if (r_active) begin
        r_timer <= r_timer + 16'd1;
        if (rx_wrreq) begin
          if (!r_echo_seen) begin
            r_echo_seen <= 1'b1;
          end else begin
            r_rd_data <= {r_rd_data[23:0], rx_data};
            r_cnt     <= r_cnt + 3'd1;
          end
        end
        if (w_done || w_tmo) r_active <= 1'b0;
      end
    end
  end

  assign o_done     = w_done;
  assign o_timeout  = w_tmo;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/dds_9952_cmd_seq.sv
// AD9952 command sequencer: turns one register command into an instruction
// byte plus data bytes pushed back-to-back into the SPI master's TX FIFO,
// and hands reads to the RX collector.
module dds_9952_cmd_seq
  import dds_9952_pkg::*;
#(
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] RX_TIMEOUT = 16'd4096
) (
  input  logic               clk,
  input  logic               n_rst,
  dds_9952_cmd_seq_if.slave  cmd,
  output logic [7:0]         tx_data,
  output logic               tx_wrreq,
  input  logic [FIFO_AW-1:0] tx_usedw,
  input  logic               tx_full,
  input  logic [7:0]         rx_data,
  input  logic               rx_wrreq,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               err,
  output logic               busy
);

  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

  state_t r_state;
  state_t w_next;

  logic        r_read;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_len;
  logic [31:0] r_shift;
  logic [2:0]  r_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_wrreq;
  logic        r_err;

  logic             w_accept;
  logic [FIFO_AW:0] w_free;
  logic [FIFO_AW:0] w_need;
  logic             w_space_ok;
  logic             w_last;
  logic             w_rx_start;
  logic             w_rx_done;
  logic             w_rx_tmo;

  assign w_accept   = cmd.cmd_valid & (r_state == ST_IDLE);
  assign w_free     = tx_full ? '0 : (DEPTH - {1'b0, tx_usedw});
  assign w_need     = (FIFO_AW+1)'(r_len + 3'd1);
  assign w_space_ok = (w_free >= w_need);
  assign w_last     = (r_state == ST_SEND) && (r_idx == r_len);
  assign w_rx_start = w_last & r_read;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_accept) w_next = ST_CHECK;
      ST_CHECK:      w_next = (r_len == 3'd0) ? ST_IDLE : ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (w_space_ok) w_next = ST_SEND;
      ST_SEND:       if (w_last) w_next = r_read ? ST_WAIT_RX : ST_IDLE;
      ST_WAIT_RX:    if (w_rx_done || w_rx_tmo) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // Command latch and registered byte stream; the first byte is launched on
  // entry to SEND so tx_wrreq is high for exactly the cycles spent in SEND.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_read     <= 1'b0;
      r_addr     <= 5'd0;
      r_data     <= 32'd0;
      r_len      <= 3'd0;
      r_shift    <= 32'd0;
      r_idx      <= 3'd0;
      r_tx_data  <= 8'd0;
      r_tx_wrreq <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= ((r_state == ST_CHECK) && (r_len == 3'd0)) || w_rx_tmo;
      r_tx_wrreq <= 1'b0;
      if (w_accept) begin
        r_read <= cmd.cmd_read;
        r_addr <= cmd.cmd_addr;
        r_data <= cmd.cmd_data;
        r_len  <= reg_len(cmd.cmd_addr);
      end
      if ((r_state == ST_WAIT_SPACE) && w_space_ok) begin
        r_tx_wrreq <= 1'b1;
        r_tx_data  <= instr_byte(r_read, r_addr);
        r_idx      <= 3'd0;
        // Left-justify the used bytes so each data byte comes off the top.
        r_shift    <= r_read ? 32'd0 : (r_data << {3'd4 - r_len, 3'b000});
      end else if (r_state == ST_SEND) begin
        if (w_last) begin
          r_tx_data <= 8'd0;
        end else begin
          r_tx_wrreq <= 1'b1;
          r_tx_data  <= r_shift[31:24];
          r_shift    <= {r_shift[23:0], 8'd0};
          r_idx      <= r_idx + 3'd1;
        end
      end
    end
  end

  dds_9952_rx_collect #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx_collect (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_start    (w_rx_start),
    .i_len      (r_len),
    .rx_data    (rx_data),
    .rx_wrreq   (rx_wrreq),
    .o_done     (w_rx_done),
    .o_timeout  (w_rx_tmo),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid)
  );

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign tx_data       = r_tx_data;
  assign tx_wrreq      = r_tx_wrreq;
  assign err           = r_err;

endmodule

// File: tb/tb_dds_9952_cmd_seq.sv
// Randomized self-checking bench for dds_9952_cmd_seq against a byte-level
// reference model of the AD9952 command protocol.
module tb_dds_9952_cmd_seq;

  localparam int          FIFO_AW = 4;
  localparam logic [15:0] RX_TO   = 16'd64;

  logic        clk;
  logic        n_rst;
  logic [7:0]  tx_data;
  logic        tx_wrreq;
  logic [3:0]  tx_usedw;
  logic        tx_full;
  logic [7:0]  rx_data;
  logic        rx_wrreq;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;
  logic        busy;

  dds_9952_cmd_seq_if cmd_if ();

  dds_9952_cmd_seq #(
    .FIFO_AW    (FIFO_AW),
    .RX_TIMEOUT (RX_TO)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cmd      (cmd_if),
    .tx_data  (tx_data),
    .tx_wrreq (tx_wrreq),
    .tx_usedw (tx_usedw),
    .tx_full  (tx_full),
    .rx_data  (rx_data),
    .rx_wrreq (rx_wrreq),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register byte lengths from the AD9952 register map; 0 = unmapped.
  int LEN_TBL [8] = '{4, 3, 2, 1, 4, 2, 0, 0};

  int n_chk  = 0;
  int n_pass = 0;

  // Monitor state, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] tx_q[$];
  int         txc_q[$];
  int         rxc_q[$];
  int         rv_n, rv_cyc, err_n, err_cyc, bf_cyc;
  logic       busy_prev = 1'b0;

  logic [7:0]  rx_bytes [5];
  logic [31:0] exp_hold = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (tx_wrreq) begin tx_q.push_back(tx_data); txc_q.push_back(cyc); end
    if (rx_wrreq) rxc_q.push_back(cyc);
    if (rd_valid) begin rv_n++; rv_cyc = cyc; end
    if (err) begin err_n++; err_cyc = cyc; end
    if (busy_prev && !busy) bf_cyc = cyc;
    busy_prev = busy;
  end

  task automatic clear_mon();
    tx_q.delete(); txc_q.delete(); rxc_q.delete();
    rv_n = 0; err_n = 0; rv_cyc = -1; err_cyc = -1; bf_cyc = -1;
  endtask

  task automatic issue(input logic rd, input logic [4:0] a, input logic [31:0] d);
    int t;
    t = 0;
    while (!cmd_if.cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ready_idle", {31'd0, cmd_if.cmd_ready}, 32'd1);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_read = rd; cmd_if.cmd_addr = a; cmd_if.cmd_data = d;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_data = $urandom; cmd_if.cmd_addr = 5'($urandom);
    chk("ready_drop", {31'd0, cmd_if.cmd_ready}, 32'd0);
  endtask

  // One full transaction. n_rx = data bytes returned after the echo.
  // blk > 0: FIFO space is withheld for blk cycles, then usedw becomes rel.
  task automatic do_cmd(input logic rd, input logic [4:0] a, input logic [31:0] d,
                        input int n_rx, input int blk, input logic [3:0] rel);
    int len, t;
    logic [7:0]  exp_b[$];
    logic [31:0] ev;
    len = (a < 5'd8) ? LEN_TBL[a] : 0;
    exp_b.delete();
    exp_b.push_back({rd, 2'b00, a});
    for (int k = 1; k <= len; k++) exp_b.push_back(rd ? 8'h00 : 8'(d >> (8 * (len - k))));
    if ($urandom_range(0, 3) == 0) begin
      rx_data = 8'h5A; rx_wrreq = 1'b1; @(posedge clk); #1; rx_wrreq = 1'b0;
    end
    clear_mon();
    issue(rd, a, d);
    if (len == 0) begin
      repeat (3) begin @(posedge clk); #1; end
      chk("bad_addr_err", err_n, 1);
      chk("bad_addr_notx", tx_q.size(), 0);
      chk("bad_addr_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk("rd_hold", rd_data, exp_hold);
      return;
    end
    if (blk > 0) begin
      repeat (blk) begin @(posedge clk); #1; end
      chk("blocked_notx", tx_q.size(), 0);
      chk("blocked_busy", {31'd0, busy}, 32'd1);
      tx_usedw = rel; tx_full = 1'b0;
    end
    t = 0;
    while (tx_q.size() < len + 1 && t < 100) begin @(posedge clk); #1; t++; end
    chk("burst_len", tx_q.size(), len + 1);
    if (tx_q.size() < len + 1) return;
    for (int k = 0; k <= len; k++) chk($sformatf("byte%0d", k), tx_q[k], exp_b[k]);
    chk("burst_contig", txc_q[len] - txc_q[0], len);
    if (!rd) begin
      repeat (2) begin @(posedge clk); #1; end
      chk("burst_noextra", tx_q.size(), len + 1);
      chk("wr_busy_fall", bf_cyc, txc_q[len] + 1);
      chk("wr_no_rdvalid", rv_n, 0);
      chk("rd_hold", rd_data, exp_hold);
      return;
    end
    ev = 32'd0;
    for (int i = 1; i <= n_rx; i++) ev = ev | (32'(rx_bytes[i]) << (8 * (n_rx - i)));
    for (int i = 0; i <= n_rx; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rx_data = rx_bytes[i]; rx_wrreq = 1'b1;
      @(posedge clk); #1;
      rx_wrreq = 1'b0;
    end
    if (n_rx >= len) begin
      repeat (2) begin @(posedge clk); #1; end
      chk("rd_valid_cnt", rv_n, 1);
      chk("rd_valid_time", rv_cyc, rxc_q[$] + 1);
      chk("rd_no_err", err_n, 0);
      chk("rd_data", rd_data, ev);
      chk("rd_busy", {31'd0, busy}, 32'd0);
    end else begin
      t = 0;
      while (err_n == 0 && t < int'(RX_TO) + 20) begin @(posedge clk); #1; t++; end
      repeat (2) begin @(posedge clk); #1; end
      chk("tmo_err_cnt", err_n, 1);
      chk("tmo_err_time", err_cyc - txc_q[len], int'(RX_TO) + 1);
      chk("tmo_no_rdvalid", rv_n, 0);
      chk("tmo_partial", rd_data, ev);
    end
    exp_hold = ev;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        rd;
    logic [4:0]  a;
    int          len, nrx, blk;
    n_rst = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_read = 1'b0; cmd_if.cmd_addr = 5'd0; cmd_if.cmd_data = 32'd0;
    tx_usedw = 4'd0; tx_full = 1'b0; rx_data = 8'd0; rx_wrreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_wrreq", {31'd0, tx_wrreq}, 32'd0);
    chk("rst_txdata", {24'd0, tx_data}, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    chk("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Directed transactions.
    do_cmd(1'b0, 5'h04, 32'h12345678, 0, 0, 4'd0);
    do_cmd(1'b0, 5'h03, 32'hFFFFFFAB, 0, 0, 4'd0);
    rx_bytes = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h00};
    do_cmd(1'b1, 5'h01, 32'hDEADBEEF, 3, 0, 4'd0);
    do_cmd(1'b0, 5'h07, 32'h0, 0, 0, 4'd0);
    tx_usedw = 4'd13;
    do_cmd(1'b0, 5'h04, 32'hCAFEF00D, 0, 6, 4'd11);
    tx_usedw = 4'd12;
    do_cmd(1'b0, 5'h04, 32'h0BADF00D, 0, 5, 4'd11);
    tx_usedw = 4'd14;
    do_cmd(1'b0, 5'h03, 32'h000000C3, 0, 0, 4'd0);
    tx_usedw = 4'd0; tx_full = 1'b1;
    do_cmd(1'b0, 5'h02, 32'h00001234, 0, 4, 4'd0);
    rx_bytes = '{8'h85, 8'h77, 8'h00, 8'h00, 8'h00};
    do_cmd(1'b1, 5'h05, 32'h0, 1, 0, 4'd0);

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      rd  = 1'($urandom);
      a   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
      len = (a < 5'd8) ? LEN_TBL[a] : 0;
      for (int i = 0; i < 5; i++) rx_bytes[i] = 8'($urandom);
      nrx = len;
      if (len > 0 && $urandom_range(0, 5) == 0) nrx = $urandom_range(0, len - 1);
      blk = 0;
      tx_full = 1'b0;
      if (len > 0 && $urandom_range(0, 3) == 0) begin
        blk = $urandom_range(1, 6);
        tx_usedw = 4'(16 - len);
      end else begin
        tx_usedw = 4'($urandom_range(0, 15 - len));
      end
      do_cmd(rd, a, $urandom, nrx, blk, 4'(15 - len));
    end

    // Asynchronous reset in the middle of a burst.
    tx_usedw = 4'd0; tx_full = 1'b0;
    clear_mon();
    issue(1'b0, 5'h00, 32'hA5A5A5A5);
    for (int t = 0; t < 20 && tx_q.size() < 2; t++) begin @(posedge clk); #1; end
    chk("midsend_started", {31'd0, tx_wrreq}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("midsend_wrreq", {31'd0, tx_wrreq}, 32'd0);
    chk("midsend_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    chk("midsend_busy", {31'd0, busy}, 32'd0);
    chk("midsend_txdata", {24'd0, tx_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    exp_hold = 32'd0;
    @(posedge clk); #1;
    do_cmd(1'b0, 5'h02, 32'h00005566, 0, 0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
